// File: rtl/move_stack_ctrl.sv
// move_stack_ctrl: LIFO controller plus 32x2-bit register file for move codes.
// The stack pointer lives in an external 5-bit up/down counter. This block only
// issues increment, decrement and clear strobes to it, then reads the count back
// through ptr and ptr_zero.
//
// Handshake: push, pop and clear are sampled on a rising edge only while
// ready = 1, which is exactly the IDLE state. When several requests arrive
// together, only the highest-priority one is acted on (clear > pop > push) and
// the others are dropped. A rejected request (push when full, pop when empty)
// leaves ready high and raises err for the single following cycle. A completed
// pop raises dout_valid for one cycle, and dout holds that entry until the next
// pop completes.
module move_stack_ctrl #(
  parameter int DW         = 2,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DW-1:0]         din,
  input  logic [DEPTH_LOG2-1:0] ptr,
  input  logic                  ptr_zero,
  output logic                  cntU,
  output logic                  cntD,
  output logic                  rst5,
  output logic                  ready,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  err,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH    = 3'd1,
    POP_DEC = 3'd2,
    POP_RD  = 3'd3,
    CLR     = 3'd4
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t          state_q, state_d;
  logic [DW-1:0]   din_q, din_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dout_q;
  logic            dout_valid_q;
  logic [DW-1:0]   mem [0:DEPTH-1];

  // Status flags come straight from the counter. The last slot is never used,
  // so the counter can never wrap from 31 back to 0.
  assign empty = ptr_zero;
  assign full  = (ptr == {DEPTH_LOG2{1'b1}});

  // Moore decode: every strobe and ready depend on the state register alone.
  assign cntU       = (state_q == PUSH);
  assign cntD       = (state_q == POP_DEC);
  assign rst5       = (state_q == CLR);
  assign ready      = (state_q == IDLE);
  assign err        = err_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign state_o    = state_q;

  // Next-state logic: pick one request in IDLE, otherwise run the fixed sequence.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLR;
        end else if (pop) begin
          if (empty) err_d = 1'b1;
          else       state_d = POP_DEC;
        end else if (push) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            state_d = PUSH;
            din_d   = din;
          end
        end
      end
      PUSH:    state_d = IDLE;
      POP_DEC: state_d = POP_RD;
      POP_RD:  state_d = IDLE;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers. In POP_RD the counter has already been decremented, so
  // ptr points at the top entry when it is read out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      din_q        <= '0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      err_q        <= err_d;
      dout_valid_q <= (state_q == POP_RD);
      if (state_q == POP_RD) dout_q <= mem[ptr];
    end
  end

  // Register file write. ptr still holds the pre-increment slot here. The
  // storage itself has no reset; a reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == PUSH) mem[ptr] <= din_q;
  end

endmodule

// File: tb/tb_move_stack_ctrl.sv
// Bench for move_stack_ctrl. It models the external 5-bit up/down counter and
// keeps a queue-based LIFO reference model of the stack contents.
module tb_move_stack_ctrl;

  logic       clk, rst, push, pop, clear;
  logic [1:0] din;
  logic [4:0] ptr;
  logic       ptr_zero;
  logic       cntU, cntD, rst5, ready, dout_valid, empty, full, err;
  logic [1:0] dout;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  logic [1:0] stack_m[$];   // reference LIFO contents
  logic [1:0] exp_q[$];     // expected popped values, in order

  int n_u = 0, n_d = 0, n_r = 0, n_v = 0, n_e = 0;

  move_stack_ctrl #(.DW(2), .DEPTH_LOG2(5)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear), .din(din),
    .ptr(ptr), .ptr_zero(ptr_zero), .cntU(cntU), .cntD(cntD), .rst5(rst5),
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .empty(empty),
    .full(full), .err(err), .state_o(state_o)
  );

  // Clock and reset environment.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External up/down counter that supplies ptr and ptr_zero.
  logic [4:0] cnt;
  always @(posedge clk) begin
    if (rst || rst5) cnt <= 5'd0;
    else if (cntU)   cnt <= cnt + 5'd1;
    else if (cntD)   cnt <= cnt - 5'd1;
  end
  assign ptr      = cnt;
  assign ptr_zero = (cnt == 5'd0);

  // Monitor and scoreboard. Strobes are counted at the falling edge, and each
  // popped value is matched against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cntU) n_u++;
      if (cntD) n_d++;
      if (rst5) n_r++;
      if (err)  n_e++;
      if (dout_valid) begin
        n_v++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dout_valid: dout=%0d with no pop outstanding", dout);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            errors++;
            $display("FAIL pop_data: got %0d expected %0d", dout, e);
          end
        end
      end
    end
  end

  // Watchdog: stop the run if it hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_status(input string tag);
    checks++;
    if (ptr !== 5'(stack_m.size())) begin
      errors++;
      $display("FAIL %s ptr: got %0d expected %0d", tag, ptr, stack_m.size());
    end
    checks++;
    if (empty !== (stack_m.size() == 0)) begin
      errors++;
      $display("FAIL %s empty: got %0b expected %0b", tag, empty, stack_m.size() == 0);
    end
    checks++;
    if (full !== (stack_m.size() == 31)) begin
      errors++;
      $display("FAIL %s full: got %0b expected %0b", tag, full, stack_m.size() == 31);
    end
  endtask

  // Run one request through the handshake and update the reference model.
  // With noise set, push is toggled at random while the block is busy; those
  // requests must be ignored.
  task automatic op(input string tag, input logic p, input logic po, input logic c,
                    input logic [1:0] d, input bit noise);
    int u0, d0, r0, v0, e0, eu, ed, er, ev, ee, n;
    eu = 0; ed = 0; er = 0; ev = 0; ee = 0;
    if (c) begin
      er = 1;
      stack_m.delete();
    end else if (po) begin
      if (stack_m.size() == 0) ee = 1;
      else begin
        ed = 1; ev = 1;
        exp_q.push_back(stack_m.pop_back());
      end
    end else if (p) begin
      if (stack_m.size() == 31) ee = 1;
      else begin
        eu = 1;
        stack_m.push_back(d);
      end
    end
    @(negedge clk);
    n = 0;
    while (!ready && n < 10) begin @(negedge clk); n++; end
    #1;
    u0 = n_u; d0 = n_d; r0 = n_r; v0 = n_v; e0 = n_e;
    push = p; pop = po; clear = c; din = d;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0; din = 2'($urandom_range(0, 3));
    n = 1;
    while (!ready && n < 10) begin
      if (noise) push = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    push = 1'b0;
    #1;
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL %s timeout: ready=%0b after %0d cycles, expected 1", tag, ready, n);
    end
    checks++;
    if ((n_u - u0) != eu) begin
      errors++; $display("FAIL %s cntU_pulses: got %0d expected %0d", tag, n_u - u0, eu);
    end
    checks++;
    if ((n_d - d0) != ed) begin
      errors++; $display("FAIL %s cntD_pulses: got %0d expected %0d", tag, n_d - d0, ed);
    end
    checks++;
    if ((n_r - r0) != er) begin
      errors++; $display("FAIL %s rst5_pulses: got %0d expected %0d", tag, n_r - r0, er);
    end
    checks++;
    if ((n_v - v0) != ev) begin
      errors++; $display("FAIL %s dout_valid_pulses: got %0d expected %0d", tag, n_v - v0, ev);
    end
    checks++;
    if ((n_e - e0) != ee) begin
      errors++; $display("FAIL %s err_pulses: got %0d expected %0d", tag, n_e - e0, ee);
    end
    check_status(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; din = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stack_m.delete();
    exp_q.delete();
    #1;
    checks++;
    if ({ready, cntU, cntD, rst5, dout_valid, err, dout} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b cntU=%0b cntD=%0b rst5=%0b dv=%0b err=%0b dout=%0d expected 1,0,0,0,0,0,0",
               ready, cntU, cntD, rst5, dout_valid, err, dout);
    end
    check_status("reset");
  endtask

  task automatic test_push_pop();
    for (int i = 1; i <= 3; i++) op("push_seq", 1'b1, 1'b0, 1'b0, 2'(i), 1'b0);
    for (int i = 0; i < 3; i++)  op("pop_seq", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_pop_empty();
    op("pop_empty", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    // err must be gone one cycle later
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle: got %0b expected 0", err);
    end
  endtask

  task automatic test_full();
    op("clr_pre_full", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 31; i++) op("fill", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    op("push_full", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    op("pop_after_full", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_priority();
    op("clr_pre_prio", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    op("prio_push1", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    op("prio_push2", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    op("prio_all", 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
    op("prio_push3", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    op("prio_pop", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset_mid_pop();
    op("clr_pre_rst", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    op("rst_fill", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    op("rst_fill", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    op("rst_fill", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    op("rst_fill", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    op("rst_fill", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    op("rst_pop", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);    // ptr = 4, dout = 1
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pop = 1'b0;
    checks++;
    if (cntD !== 1'b1) begin
      errors++; $display("FAIL rst_in_pop_dec: cntD=%0b expected 1", cntD);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stack_m.delete();
    #1;
    checks++;
    if ({ready, dout_valid, dout} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_pop: ready=%0b dv=%0b dout=%0d expected 1,0,0", ready, dout_valid, dout);
    end
    check_status("rst_mid_pop");
  endtask

  task automatic test_busy_ignore();
    op("busy_push", 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
    op("busy_push", 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    op("busy_pop", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    op("busy_pop", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      int k;
      logic p, po, c;
      k  = $urandom_range(0, 99);
      c  = (k < 5);
      po = (k >= 5 && k < 45) || (k % 7 == 0);
      p  = (k >= 40) || (k % 5 == 0);
      op("random", p, po, c, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_pop_empty();
    test_full();
    test_priority();
    test_reset_mid_pop();
    test_busy_ignore();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_pops: %0d popped values never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
